// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_adder_ctrl_pkg;

    // Sequencer states; encodings are fixed so that debug probes read the same everywhere.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Legal operand widths for the sequencer.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Bit-counter width: enough to index every operand bit, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Gate-level one-bit full-adder cell shared by every bit position of the serial add.
module serial_adder_ctrl_fa (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic axb;

    assign axb  = a ^ b;
    assign sum  = axb ^ cin;
    assign cout = (a & b) | (axb & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one full-adder cell, LSB first, registered carry.
// Handshake: start accepted in IDLE, busy in RUN/DONE, one-cycle done pulse with result.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] s_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             cell_sum;
    logic             cell_cout;
    logic             last_bit;

    // The single adder cell sees the current LSBs and the running carry.
    serial_adder_ctrl_fa u_fa (
        .sum  (cell_sum),
        .cout (cell_cout),
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg)
    );

    assign last_bit = (cnt_reg == CNT_LAST);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; any unexpected encoding falls back to IDLE.
    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand/partial-sum shifting, carry and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_sh_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        s_sh_reg  <= '0;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                    end
                end
                S_RUN: begin
                    a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    s_sh_reg  <= {cell_sum, s_sh_reg[WIDTH-1:1]};
                    carry_reg <= cell_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                end
                S_DONE: begin
                end
                default: begin
                    cnt_reg   <= '0;
                    carry_reg <= 1'b0;
                    a_sh_reg  <= '0;
                    b_sh_reg  <= '0;
                    s_sh_reg  <= '0;
                end
            endcase
        end
    end

    // Result registers load with the last bit so they are already valid while done is high,
    // and otherwise hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else if (state_reg == S_RUN && last_bit) begin
            sum_reg  <= {cell_sum, s_sh_reg[WIDTH-1:1]};
            cout_reg <= cell_cout;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        busy = (state_reg == S_RUN) || (state_reg == S_DONE);
        done = (state_reg == S_DONE);
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
